// File: rtl/player_ctrl.sv
// Player input controller: turns debounced switch levels into cannon moves
// with hold-to-repeat, a fire request handshake with cooldown, and a start pulse.
module player_ctrl #(
  parameter int unsigned TICK_DIV      = 120000,
  parameter int unsigned REPEAT_DELAY  = 30,
  parameter int unsigned REPEAT_RATE   = 8,
  parameter int unsigned FIRE_COOLDOWN = 25,
  parameter int unsigned X_MAX         = 29,
  parameter int unsigned X_INIT        = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_left,
  input  logic       sw_right,
  input  logic       sw_fire,
  input  logic       sw_start,
  input  logic       game_en,
  input  logic       fire_ack,
  output logic [4:0] player_x,
  output logic       fire_req,
  output logic       start_pulse
);

  localparam int unsigned X_W      = 5;
  localparam int unsigned TICK_W   = $clog2(TICK_DIV + 1);
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 2);
  localparam int unsigned CD_W     = $clog2(FIRE_COOLDOWN + 2);

  typedef enum logic [1:0] {MV_IDLE, MV_DELAY, MV_REPEAT} mv_state_e;

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]        sw_prev_q, sw_prev_d;
  logic [3:0]        armed_q, armed_d;
  mv_state_e         mv_state_q [2];
  mv_state_e         mv_state_d [2];
  logic [HOLD_W-1:0] hold_q [2];
  logic [HOLD_W-1:0] hold_d [2];
  logic [X_W-1:0]    player_x_q, player_x_d;
  logic              fire_req_q, fire_req_d;
  logic [CD_W-1:0]   cooldown_q, cooldown_d;
  logic              start_pulse_q, start_pulse_d;

  logic [3:0]        sw_vec;
  logic [3:0]        press;
  logic [1:0]        lvl;
  logic [1:0]        step;
  logic [HOLD_W-1:0] hold_inc;
  logic              tick;
  logic              start_press;
  logic              freeze;

  always_comb begin
    sw_vec      = {sw_start, sw_fire, sw_right, sw_left};
    sw_prev_d   = sw_vec;
    // A switch arms once it has been seen released after reset.
    armed_d     = armed_q | ~sw_vec;
    press       = sw_vec & ~sw_prev_q & armed_q;
    lvl         = {sw_right, sw_left} & armed_q[1:0];
    start_press = press[3];

    tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    // Moves stop while disabled, while both directions are held, or on start.
    freeze   = !game_en || (lvl[0] && lvl[1]) || start_press;
    step     = '0;
    hold_inc = '0;
    for (int d = 0; d < 2; d++) begin
      mv_state_d[d] = mv_state_q[d];
      hold_d[d]     = hold_q[d];
      hold_inc      = hold_q[d] + HOLD_W'(1);
      if (freeze) begin
        mv_state_d[d] = MV_IDLE;
        hold_d[d]     = '0;
      end else begin
        case (mv_state_q[d])
          MV_IDLE: begin
            if (press[d]) begin
              step[d]       = 1'b1;
              mv_state_d[d] = MV_DELAY;
              hold_d[d]     = '0;
            end
          end
          MV_DELAY: begin
            if (!lvl[d]) begin
              mv_state_d[d] = MV_IDLE;
              hold_d[d]     = '0;
            end else if (tick) begin
              if (hold_inc == HOLD_W'(REPEAT_DELAY)) begin
                step[d]       = 1'b1;
                mv_state_d[d] = MV_REPEAT;
                hold_d[d]     = '0;
              end else begin
                hold_d[d] = hold_inc;
              end
            end
          end
          MV_REPEAT: begin
            if (!lvl[d]) begin
              mv_state_d[d] = MV_IDLE;
              hold_d[d]     = '0;
            end else if (tick) begin
              if (hold_inc == HOLD_W'(REPEAT_RATE)) begin
                step[d]   = 1'b1;
                hold_d[d] = '0;
              end else begin
                hold_d[d] = hold_inc;
              end
            end
          end
          default: begin
            mv_state_d[d] = MV_IDLE;
            hold_d[d]     = '0;
          end
        endcase
      end
    end

    player_x_d = player_x_q;
    if (start_press) begin
      player_x_d = X_W'(X_INIT);
    end else if (step[1] && (player_x_q != X_W'(X_MAX))) begin
      player_x_d = player_x_q + X_W'(1);
    end else if (step[0] && (player_x_q != '0)) begin
      player_x_d = player_x_q - X_W'(1);
    end

    // Fire handshake: request held until acked, then cooldown blocks new presses.
    fire_req_d = fire_req_q;
    cooldown_d = cooldown_q;
    if (start_press) begin
      fire_req_d = 1'b0;
      cooldown_d = '0;
    end else if (fire_req_q && fire_ack) begin
      fire_req_d = 1'b0;
      cooldown_d = CD_W'(FIRE_COOLDOWN);
    end else if (!fire_req_q && (cooldown_q == '0) && press[2] && game_en) begin
      fire_req_d = 1'b1;
    end else if ((cooldown_q != '0) && tick) begin
      cooldown_d = cooldown_q - CD_W'(1);
    end

    start_pulse_d = start_press;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt_q    <= '0;
      sw_prev_q     <= '0;
      armed_q       <= '0;
      player_x_q    <= X_W'(X_INIT);
      fire_req_q    <= 1'b0;
      cooldown_q    <= '0;
      start_pulse_q <= 1'b0;
      for (int d = 0; d < 2; d++) begin
        mv_state_q[d] <= MV_IDLE;
        hold_q[d]     <= '0;
      end
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      sw_prev_q     <= sw_prev_d;
      armed_q       <= armed_d;
      player_x_q    <= player_x_d;
      fire_req_q    <= fire_req_d;
      cooldown_q    <= cooldown_d;
      start_pulse_q <= start_pulse_d;
      for (int d = 0; d < 2; d++) begin
        mv_state_q[d] <= mv_state_d[d];
        hold_q[d]     <= hold_d[d];
      end
    end
  end

  assign player_x    = player_x_q;
  assign fire_req    = fire_req_q;
  assign start_pulse = start_pulse_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed self-checking bench for player_ctrl with shortened timing parameters.
module tb_player_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       sw_left, sw_right, sw_fire, sw_start;
  logic       game_en, fire_ack;
  logic [4:0] player_x;
  logic       fire_req, start_pulse;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  player_ctrl #(
    .TICK_DIV      (4),
    .REPEAT_DELAY  (3),
    .REPEAT_RATE   (2),
    .FIRE_COOLDOWN (2),
    .X_MAX         (29),
    .X_INIT        (14)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_left     (sw_left),
    .sw_right    (sw_right),
    .sw_fire     (sw_fire),
    .sw_start    (sw_start),
    .game_en     (game_en),
    .fire_ack    (fire_ack),
    .player_x    (player_x),
    .fire_req    (fire_req),
    .start_pulse (start_pulse)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_x_change(input int limit, output int ncyc);
    logic [4:0] old;
    old  = player_x;
    ncyc = 0;
    while ((player_x == old) && (ncyc < limit)) begin
      cyc(1);
      ncyc++;
    end
  endtask

  initial begin
    int bad;
    int n;

    reset    = 1'b0;
    sw_left  = 1'b1;
    sw_right = 1'b1;
    sw_fire  = 1'b1;
    sw_start = 1'b1;
    game_en  = 1'b1;
    fire_ack = 1'b0;
    cyc(3);
    check("rst_x", player_x, 14);
    check("rst_fire_req", fire_req, 0);
    check("rst_start_pulse", start_pulse, 0);

    // Power-up level of 1 must not count as a press.
    reset = 1'b1;
    bad   = 0;
    repeat (100) begin
      cyc(1);
      if ((player_x != 5'd14) || fire_req || start_pulse) bad++;
    end
    check("unarmed_quiet", bad, 0);

    sw_left  = 1'b0;
    sw_right = 1'b0;
    sw_fire  = 1'b0;
    sw_start = 1'b0;
    cyc(2);

    sw_right = 1'b1;
    cyc(1);
    check("right_press", player_x, 15);
    cyc(3);
    sw_right = 1'b0;
    cyc(4);
    check("right_tap_no_repeat", player_x, 15);

    sw_left = 1'b1;
    cyc(1);
    check("left_press", player_x, 14);
    wait_x_change(20, n);
    check("left_first_repeat_x", player_x, 13);
    check("left_first_repeat_window", int'((n >= 9) && (n <= 12)), 1);
    wait_x_change(12, n);
    check("left_repeat1_x", player_x, 12);
    check("left_repeat1_gap", n, 8);
    wait_x_change(12, n);
    check("left_repeat2_x", player_x, 11);
    check("left_repeat2_gap", n, 8);
    sw_left = 1'b0;
    cyc(10);
    check("left_release_hold", player_x, 11);

    sw_right = 1'b1;
    cyc(250);
    check("right_saturate", player_x, 29);
    sw_right = 1'b0;
    cyc(2);
    sw_left = 1'b1;
    cyc(300);
    check("left_saturate", player_x, 0);
    cyc(20);
    check("left_no_wrap", player_x, 0);
    sw_left = 1'b0;
    cyc(2);

    sw_fire = 1'b1;
    cyc(1);
    sw_fire = 1'b0;
    check("fire_accept", fire_req, 1);
    bad = 0;
    repeat (10) begin
      cyc(1);
      if (!fire_req) bad++;
    end
    check("fire_held_no_ack", bad, 0);
    fire_ack = 1'b1;
    cyc(1);
    fire_ack = 1'b0;
    check("fire_drop_on_ack", fire_req, 0);
    sw_fire = 1'b1;
    cyc(1);
    sw_fire = 1'b0;
    check("fire_in_cooldown", fire_req, 0);
    cyc(1);
    check("fire_in_cooldown_late", fire_req, 0);
    cyc(12);
    fire_ack = 1'b1;
    cyc(1);
    fire_ack = 1'b0;
    check("ack_while_idle", fire_req, 0);
    sw_fire = 1'b1;
    cyc(1);
    sw_fire = 1'b0;
    check("fire_after_cooldown", fire_req, 1);
    fire_ack = 1'b1;
    cyc(1);
    fire_ack = 1'b0;
    check("fire_drop_2", fire_req, 0);
    cyc(12);

    game_en  = 1'b0;
    sw_fire  = 1'b1;
    sw_right = 1'b1;
    cyc(1);
    check("disabled_fire", fire_req, 0);
    check("disabled_move", player_x, 0);
    cyc(15);
    check("disabled_hold", player_x, 0);
    sw_fire  = 1'b0;
    sw_right = 1'b0;
    game_en  = 1'b1;
    cyc(2);

    sw_right = 1'b1;
    cyc(1);
    sw_right = 1'b0;
    check("tap_to_1", player_x, 1);
    cyc(2);
    sw_left  = 1'b1;
    sw_right = 1'b1;
    cyc(20);
    check("both_held", player_x, 1);
    sw_right = 1'b0;
    cyc(20);
    check("one_released_no_move", player_x, 1);
    sw_left = 1'b0;
    cyc(2);
    sw_left = 1'b1;
    cyc(1);
    check("left_repress", player_x, 0);
    sw_left = 1'b0;
    cyc(2);

    sw_fire = 1'b1;
    cyc(1);
    sw_fire = 1'b0;
    check("fire_before_start", fire_req, 1);
    sw_right = 1'b1;
    cyc(1);
    check("right_before_start", player_x, 1);
    cyc(20);
    sw_start = 1'b1;
    cyc(1);
    check("start_pulse_hi", start_pulse, 1);
    check("start_x", player_x, 14);
    check("start_fire_clr", fire_req, 0);
    cyc(1);
    check("start_pulse_lo", start_pulse, 0);
    sw_start = 1'b0;
    cyc(20);
    check("start_fsm_idle", player_x, 14);
    sw_right = 1'b0;
    cyc(2);

    sw_left = 1'b1;
    cyc(1);
    check("pre_reset_left", player_x, 13);
    sw_fire = 1'b1;
    cyc(1);
    sw_fire = 1'b0;
    check("pre_reset_fire", fire_req, 1);
    cyc(12);
    reset = 1'b0;
    cyc(1);
    check("midrst_x", player_x, 14);
    check("midrst_fire_req", fire_req, 0);
    check("midrst_start_pulse", start_pulse, 0);
    reset = 1'b1;
    cyc(20);
    check("post_rst_unarmed_x", player_x, 14);
    check("post_rst_fire_req", fire_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
